// File: rtl/csr_trap_unit_pkg.sv
// Shared CSR op encoding, machine-mode CSR addresses and field indices
// used by the CSR/trap unit and the decoder.
package csr_trap_unit_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MCAUSE_IRQ_BIT = 31;
    localparam int unsigned IRQ_BASE       = 16;

endpackage

// File: rtl/csr_trap_unit_counter.sv
// Free-running counter with 32-bit half writes; a write to either half
// suppresses the increment for that cycle.
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [WIDTH-1:0] count
);

    generate
        if (WIDTH > 32) begin : g_wide
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (wr_lo || wr_hi) begin
                    if (wr_lo) count[31:0] <= wdata;
                    if (wr_hi) count[WIDTH-1:32] <= wdata[WIDTH-33:0];
                end else if (inc) begin
                    count <= count + WIDTH'(1);
                end
            end
        end else begin : g_narrow
            // A single half exists, so either write strobe replaces it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (wr_lo || wr_hi) begin
                    count <= wdata;
                end else if (inc) begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/mret, interrupt masking,
// vectored mtvec and cycle/instret counters.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] TVEC_ADDRESS = 32'h0,
    parameter int          NUM_IRQ      = 4,
    parameter int          CNT_WIDTH    = 64,
    parameter logic [31:0] HART_ID      = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         op_i,
    input  logic [11:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               illegal_o,
    input  logic               retire_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               trap_i,
    input  logic               trap_is_irq_i,
    input  logic [4:0]         trap_cause_i,
    input  logic [31:0]        pc_i,
    input  logic               mret_i,
    output logic [31:0]        epc_o,
    output logic [31:0]        tvec_o,
    output logic               irq_pending_o,
    output logic [4:0]         irq_cause_o
);

    csr_op_e              op;
    logic                 mie_q, mpie_q;
    logic [NUM_IRQ-1:0]   mie_en_q, mip_q, pend;
    logic [31:0]          mtvec_q, mscratch_q, mepc_q, mtvec_base;
    logic                 mcause_irq_q;
    logic [4:0]           mcause_code_q, cause_c;
    logic [CNT_WIDTH-1:0] mcycle, minstret;
    logic [31:0]          cyc_hi, ins_hi, wval;
    logic                 impl, ro, wr_en;

    assign op = csr_op_e'(op_i);

    always_comb begin
        impl    = 1'b1;
        ro      = 1'b0;
        rdata_o = '0;
        case (addr_i)
            CSR_MSTATUS: begin
                rdata_o[12:11]        = 2'b11;
                rdata_o[MSTATUS_MIE]  = mie_q;
                rdata_o[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MIE:      rdata_o[IRQ_BASE +: NUM_IRQ] = mie_en_q;
            CSR_MTVEC:    rdata_o = mtvec_q;
            CSR_MSCRATCH: rdata_o = mscratch_q;
            CSR_MEPC:     rdata_o = mepc_q;
            CSR_MCAUSE: begin
                rdata_o[MCAUSE_IRQ_BIT] = mcause_irq_q;
                rdata_o[4:0]            = mcause_code_q;
            end
            CSR_MIP: begin
                rdata_o[IRQ_BASE +: NUM_IRQ] = mip_q;
                ro = 1'b1;
            end
            CSR_MHARTID: begin
                rdata_o = HART_ID;
                ro = 1'b1;
            end
            CSR_MCYCLE:    rdata_o = mcycle[31:0];
            CSR_MINSTRET:  rdata_o = minstret[31:0];
            CSR_MCYCLEH:   if (CNT_WIDTH == 64) rdata_o = cyc_hi; else impl = 1'b0;
            CSR_MINSTRETH: if (CNT_WIDTH == 64) rdata_o = ins_hi; else impl = 1'b0;
            default:       impl = 1'b0;
        endcase
    end

    assign illegal_o = (op != CSR_NONE) && (!impl || ro);
    assign wr_en     = (op != CSR_NONE) && !illegal_o;

    always_comb begin
        case (op)
            CSR_WRITE: wval = wdata_i;
            CSR_SET:   wval = rdata_o | wdata_i;
            CSR_CLEAR: wval = rdata_o & ~wdata_i;
            default:   wval = rdata_o;
        endcase
    end

    assign pend = mip_q & mie_en_q;

    always_comb begin
        logic found;
        found   = 1'b0;
        cause_c = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !found) begin
                found   = 1'b1;
                cause_c = 5'(IRQ_BASE + i);
            end
        end
    end

    assign mtvec_base = {mtvec_q[31:2], 2'b00};
    assign tvec_o = (mtvec_q[1:0] == MTVEC_VECTORED && trap_is_irq_i)
                  ? mtvec_base + {25'b0, trap_cause_i, 2'b00} : mtvec_base;
    assign epc_o  = mepc_q;

    // Priority on shared state: trap > mret > CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mie_en_q      <= '0;
            mip_q         <= '0;
            mtvec_q       <= TVEC_ADDRESS;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_irq_q  <= 1'b0;
            mcause_code_q <= '0;
            irq_pending_o <= 1'b0;
            irq_cause_o   <= '0;
        end else begin
            mip_q         <= irq_i;
            irq_pending_o <= mie_q & (|pend);
            irq_cause_o   <= cause_c;

            if (wr_en) begin
                case (addr_i)
                    CSR_MIE:      mie_en_q   <= wval[IRQ_BASE +: NUM_IRQ];
                    CSR_MTVEC:    mtvec_q    <= {wval[31:2], (wval[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
                    CSR_MSCRATCH: mscratch_q <= wval;
                    default: ;
                endcase
            end

            if (trap_i) begin
                mpie_q <= mie_q;
                mie_q  <= 1'b0;
            end else if (mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (wr_en && addr_i == CSR_MSTATUS) begin
                mie_q  <= wval[MSTATUS_MIE];
                mpie_q <= wval[MSTATUS_MPIE];
            end

            if (trap_i) begin
                mepc_q        <= pc_i & ~32'h3;
                mcause_irq_q  <= trap_is_irq_i;
                mcause_code_q <= trap_cause_i;
            end else if (wr_en && addr_i == CSR_MEPC) begin
                mepc_q <= wval & ~32'h3;
            end else if (wr_en && addr_i == CSR_MCAUSE) begin
                mcause_irq_q  <= wval[MCAUSE_IRQ_BIT];
                mcause_code_q <= wval[4:0];
            end
        end
    end

    csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (wr_en && addr_i == CSR_MCYCLE),
        .wr_hi (wr_en && addr_i == CSR_MCYCLEH),
        .wdata (wval),
        .count (mcycle)
    );

    csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_i),
        .wr_lo (wr_en && addr_i == CSR_MINSTRET),
        .wr_hi (wr_en && addr_i == CSR_MINSTRETH),
        .wdata (wval),
        .count (minstret)
    );

    generate
        if (CNT_WIDTH == 64) begin : g_hi
            assign cyc_hi = mcycle[CNT_WIDTH-1:32];
            assign ins_hi = minstret[CNT_WIDTH-1:32];
        end else begin : g_no_hi
            assign cyc_hi = '0;
            assign ins_hi = '0;
        end
    endgenerate

endmodule
